// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB slave.
// Imported by the interface, the storage block and the top.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int PPROT_PRIV = 0;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_slave_param_if.sv
// APB4 bus bundle between a master and the parametrised slave.
// Master drives request fields; slave returns ready/error/data.
interface apb_slave_param_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic                                   psel;
  logic                                   penable;
  logic                                   pwrite;
  logic [ADDR_W-1:0]                      addr;
  logic [DATA_W-1:0]                      pwdata;
  logic [apb_pkg::strb_w(DATA_W)-1:0]     pstrb;
  logic [2:0]                             pprot;
  logic                                   pready;
  logic                                   pslverr;
  logic [DATA_W-1:0]                      prdata;

  modport master (
    output psel, penable, pwrite, addr,
    output pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, addr,
    input  pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_bytemem.sv
// Word storage with per-byte write enables and async clear.
// Read port is combinational; out-of-range reads return zero.
module apb_bytemem
  import apb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  localparam int SW    = strb_w(DATA_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SW-1:0]     wstrb,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // clear everything on reset, else merge enabled byte lanes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++)
        if (waddr == ADDR_W'(i))
          for (int b = 0; b < SW; b++)
            if (wstrb[b])
              mem[i][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // decoded read mux
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (raddr == ADDR_W'(i))
        rdata = mem[i];
  end

endmodule

// File: rtl/apb_slave_param.sv
// Parametrised APB4 slave: wait states, byte strobes,
// privileged-write region and out-of-range error reporting.
module apb_slave_param
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2,
  parameter int PRIV_BASE   = DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  apb_slave_param_if.slave  bus
);

  localparam int SW    = strb_w(DATA_W);
  localparam int CNT_W =
    (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     strb_q;
  logic              err_q;

  logic              setup;
  logic              err_in;
  logic              cur_err;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;

  logic              mem_we;
  logic [DATA_W-1:0] rdata;

  logic              pready_d, pslverr_d;
  logic [DATA_W-1:0] prdata_d;
  logic              pready_q, pslverr_q;
  logic [DATA_W-1:0] prdata_q;

  logic              unused_prot;

  assign unused_prot = ^bus.pprot;

  assign setup  = bus.psel & ~bus.penable;
  assign err_in =
    (32'(bus.addr) >= 32'(DEPTH)) |
    (bus.pwrite & ~bus.pprot[PPROT_PRIV] &
     (32'(bus.addr) >= 32'(PRIV_BASE)));

  // with zero wait states ACCESS follows IDLE directly,
  // so the first access cycle decodes from the live bus
  assign cur_err  = (state == IDLE) ? err_in     : err_q;
  assign cur_wr   = (state == IDLE) ? bus.pwrite : wr_q;
  assign cur_addr = (state == IDLE) ? bus.addr   : addr_q;

  assign mem_we = (state == ACCESS) & bus.psel &
                  bus.penable & wr_q & ~err_q;

  // state, wait counter and setup-phase request capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && setup) begin
        addr_q  <= bus.addr;
        wr_q    <= bus.pwrite;
        wdata_q <= bus.pwdata;
        strb_q  <= bus.pstrb;
        err_q   <= err_in;
      end
    end
  end

  // next-state and wait-count decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (setup) begin
          if (WAIT_STATES == 0) begin
            state_n = ACCESS;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!bus.psel)
          state_n = IDLE;
        else if (cnt == '0)
          state_n = ACCESS;
        else
          cnt_n = cnt - 1'b1;
      end
      ACCESS: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // response values registered alongside pready
  always_comb begin
    pready_d  = (state_n == ACCESS);
    pslverr_d = pready_d & cur_err;
    prdata_d  = '0;
    if (pready_d && !cur_wr && !cur_err)
      prdata_d = rdata;
  end

  // response output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

  apb_bytemem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (clk),
    .resetn (resetn),
    .we     (mem_we),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .wstrb  (strb_q),
    .raddr  (cur_addr),
    .rdata  (rdata)
  );

endmodule
